mem_responder: RTL and testbench

- Word-addressed memory responder that serves the datapath's memory-side requests: Read/Write strobes, a MAR address and MDR write data.
- Returns read data for the MDR input and a one-cycle Ready completion pulse.
- Inserts a programmable number of wait states so the control unit's memory handshake is exercised with non-zero latency.
- Replaces the zero-latency RAM as the far end of the MAR/MDR interface.

---
 rtl/mem_responder.sv | 101 ++++++++++
 tb/tb_mem_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states: accepts one
// Read/Write request at a time and answers with a one-cycle Ready (and Error) pulse.
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Ready,
    output logic                  Busy,
    output logic                  Error
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  op_wr;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign idx      = addr_q[IDX_W-1:0];

    // Array has no reset so its contents survive Reset; an aborted access never
    // reaches ACCESS because the FSM is held in IDLE asynchronously.
    always_ff @(posedge Clock) begin
        if (state == S_ACCESS && op_wr && in_range)
            mem[idx] <= data_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_wr   <= 1'b0;
            DataOut <= '0;
            Ready   <= 1'b0;
            Busy    <= 1'b0;
            Error   <= 1'b0;
        end else begin
            Ready <= 1'b0;
            Error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Read && Write) begin
                        // Conflicting strobes: complete immediately with Error, no access.
                        state <= S_DONE;
                        Busy  <= 1'b1;
                        Ready <= 1'b1;
                        Error <= 1'b1;
                    end else if (Read ^ Write) begin
                        addr_q <= Address;
                        data_q <= DataIn;
                        op_wr  <= Write;
                        cnt    <= '0;
                        Busy   <= 1'b1;
                        state  <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == WAIT_LAST)
                        state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!in_range)
                        Error <= 1'b1;
                    else if (!op_wr)
                        DataOut <= mem[idx];
                    Ready <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (2 wait states, 0 wait
// states, and a 256-word array) driven by per-scenario tasks.
module tb_mem_responder;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        rd   [3];
    logic        wr   [3];
    logic [8:0]  addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic        rdy  [3];
    logic        bsy  [3];
    logic        err  [3];

    int vectors = 0;
    int errors  = 0;

    always #5 Clock = ~Clock;

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(2)) dut_w2 (
        .Clock(Clock), .Reset(Reset), .Read(rd[0]), .Write(wr[0]), .Address(addr[0]),
        .DataIn(din[0]), .DataOut(dout[0]), .Ready(rdy[0]), .Busy(bsy[0]), .Error(err[0]));
    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(0)) dut_w0 (
        .Clock(Clock), .Reset(Reset), .Read(rd[1]), .Write(wr[1]), .Address(addr[1]),
        .DataIn(din[1]), .DataOut(dout[1]), .Ready(rdy[1]), .Busy(bsy[1]), .Error(err[1]));
    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) dut_d256 (
        .Clock(Clock), .Reset(Reset), .Read(rd[2]), .Write(wr[2]), .Address(addr[2]),
        .DataIn(din[2]), .DataOut(dout[2]), .Ready(rdy[2]), .Busy(bsy[2]), .Error(err[2]));

    // Issue one request on instance i and wait (bounded) for Ready.
    // lat = edges after the request edge E0 (-1 on timeout); busy_n = Busy samples
    // through the Ready cycle; idle = Ready and Busy both low one cycle after Ready.
    task automatic do_req(input int i, input logic r, input logic w, input logic [8:0] a,
                          input logic [31:0] d, output int lat, output int busy_n,
                          output logic e, output logic [31:0] q, output logic idle);
        rd[i] = r; wr[i] = w; addr[i] = a; din[i] = d;
        lat = -1; busy_n = 0; e = 1'b0; q = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge Clock); #1;
            if (bsy[i]) busy_n++;
            if (rdy[i]) begin
                lat = k; e = err[i]; q = dout[i];
                break;
            end
        end
        rd[i] = 1'b0; wr[i] = 1'b0;
        @(posedge Clock); #1;
        idle = !rdy[i] && !bsy[i];
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock); #1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (dout[i] !== 32'h0) begin errors++; $display("FAIL reset_dout[%0d]: got %h want 0", i, dout[i]); end
            vectors++; if (rdy[i] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 0", i, rdy[i]); end
            vectors++; if (bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, bsy[i]); end
            vectors++; if (err[i] !== 1'b0) begin errors++; $display("FAIL reset_error[%0d]: got %b want 0", i, err[i]); end
        end
    endtask

    task automatic test_wait_states();
        int lat, bn; logic e, idle; logic [31:0] q;
        do_req(0, 1'b0, 1'b1, 9'h014, 32'hDEADBEEF, lat, bn, e, q, idle);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL w2_wr_latency: got %0d want 3", lat); end
        vectors++; if (bn !== 4) begin errors++; $display("FAIL w2_wr_busy: got %0d want 4", bn); end
        vectors++; if (e !== 1'b0) begin errors++; $display("FAIL w2_wr_error: got %b want 0", e); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL w2_wr_idle_after: got %b want 1", idle); end
        do_req(0, 1'b1, 1'b0, 9'h014, 32'h0, lat, bn, e, q, idle);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL w2_rd_latency: got %0d want 3", lat); end
        vectors++; if (bn !== 4) begin errors++; $display("FAIL w2_rd_busy: got %0d want 4", bn); end
        vectors++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL w2_rd_data: got %h want deadbeef", q); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL w2_rd_idle_after: got %b want 1", idle); end
        vectors++; if (dout[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL w2_rd_hold: got %h want deadbeef", dout[0]); end
    endtask

    task automatic test_back_to_back();
        int lat, bn; logic e, idle; logic [31:0] q;
        do_req(1, 1'b0, 1'b1, 9'h1FF, 32'h00000055, lat, bn, e, q, idle);
        vectors++; if (lat !== 1) begin errors++; $display("FAIL w0_wr_latency: got %0d want 1", lat); end
        vectors++; if (bn !== 2) begin errors++; $display("FAIL w0_wr_busy: got %0d want 2", bn); end
        do_req(1, 1'b1, 1'b0, 9'h1FF, 32'h0, lat, bn, e, q, idle);
        vectors++; if (lat !== 1) begin errors++; $display("FAIL w0_rd_latency: got %0d want 1", lat); end
        vectors++; if (q !== 32'h00000055) begin errors++; $display("FAIL w0_rd_data: got %h want 00000055", q); end
        vectors++; if (e !== 1'b0) begin errors++; $display("FAIL w0_rd_error: got %b want 0", e); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL w0_rd_idle_after: got %b want 1", idle); end
    endtask

    task automatic test_both_high();
        int lat, bn; logic e, idle; logic [31:0] q;
        do_req(0, 1'b0, 1'b1, 9'h003, 32'h12345678, lat, bn, e, q, idle);
        do_req(0, 1'b1, 1'b0, 9'h014, 32'h0, lat, bn, e, q, idle);
        do_req(0, 1'b1, 1'b1, 9'h003, 32'hAAAAAAAA, lat, bn, e, q, idle);
        vectors++; if (lat !== 0) begin errors++; $display("FAIL both_latency: got %0d want 0", lat); end
        vectors++; if (e !== 1'b1) begin errors++; $display("FAIL both_error: got %b want 1", e); end
        vectors++; if (bn !== 1) begin errors++; $display("FAIL both_busy: got %0d want 1", bn); end
        vectors++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL both_dout_kept: got %h want deadbeef", q); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL both_idle_after: got %b want 1", idle); end
        do_req(0, 1'b1, 1'b0, 9'h003, 32'h0, lat, bn, e, q, idle);
        vectors++; if (q !== 32'h12345678) begin errors++; $display("FAIL both_mem_kept: got %h want 12345678", q); end
        vectors++; if (e !== 1'b0) begin errors++; $display("FAIL both_rd_error: got %b want 0", e); end
    endtask

    task automatic test_out_of_range();
        int lat, bn; logic e, idle; logic [31:0] q;
        do_req(2, 1'b0, 1'b1, 9'h000, 32'h0, lat, bn, e, q, idle);
        do_req(2, 1'b0, 1'b1, 9'h0FF, 32'h11111111, lat, bn, e, q, idle);
        vectors++; if (e !== 1'b0) begin errors++; $display("FAIL oor_last_wr_error: got %b want 0", e); end
        do_req(2, 1'b0, 1'b1, 9'h100, 32'hFFFFFFFF, lat, bn, e, q, idle);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL oor_wr_latency: got %0d want 3", lat); end
        vectors++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_error: got %b want 1", e); end
        do_req(2, 1'b1, 1'b0, 9'h000, 32'h0, lat, bn, e, q, idle);
        vectors++; if (q !== 32'h0) begin errors++; $display("FAIL oor_rd0_data: got %h want 0", q); end
        vectors++; if (e !== 1'b0) begin errors++; $display("FAIL oor_rd0_error: got %b want 0", e); end
        do_req(2, 1'b1, 1'b0, 9'h0FF, 32'h0, lat, bn, e, q, idle);
        vectors++; if (q !== 32'h11111111) begin errors++; $display("FAIL oor_rd_last: got %h want 11111111", q); end
        do_req(2, 1'b1, 1'b0, 9'h100, 32'h0, lat, bn, e, q, idle);
        vectors++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_error: got %b want 1", e); end
        vectors++; if (q !== 32'h11111111) begin errors++; $display("FAIL oor_rd_dout_kept: got %h want 11111111", q); end
    endtask

    task automatic test_reset_abort();
        int lat, bn, seen; logic e, idle; logic [31:0] q;
        do_req(0, 1'b0, 1'b1, 9'h020, 32'h0, lat, bn, e, q, idle);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 9'h020; din[0] = 32'hCAFEF00D;
        @(posedge Clock); #1;               // E0: now in WAIT
        @(posedge Clock); #1;               // still in WAIT
        Reset = 1'b0;
        #1;
        vectors++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bsy[0]); end
        vectors++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", rdy[0]); end
        wr[0] = 1'b0;
        @(posedge Clock); #1 Reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clock); #1;
            if (rdy[0]) seen++;
        end
        vectors++; if (seen !== 0) begin errors++; $display("FAIL abort_no_ready: got %0d pulses want 0", seen); end
        do_req(0, 1'b1, 1'b0, 9'h020, 32'h0, lat, bn, e, q, idle);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL abort_rd_latency: got %0d want 3", lat); end
        vectors++; if (q !== 32'h0) begin errors++; $display("FAIL abort_mem_unchanged: got %h want 0", q); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; din[i] = '0;
        end
        test_reset();
        test_wait_states();
        test_back_to_back();
        test_both_high();
        test_out_of_range();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
